// File: rtl/lsu.sv
// Load/store unit driving a word-only, async-read/sync-write data memory.
// Latency: load 2 cycles, word store 2, sub-word store 3 (read-modify-write), error 2.
// Backpressure: req_ready only in IDLE; the response is held in RESP until resp_ready.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata   core request
//   resp_valid/resp_ready/resp_rdata/resp_err                             core response
//   mem_we/mem_addr/mem_wdata/mem_rdata                                   data memory port
module lsu #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, READ, WRITE, ERR, RESP} state_t;

   state_t                  state, state_nxt;
   logic                    we_q;
   logic [1:0]              size_q;
   logic                    uns_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   word_q;

   logic                    req_bad;
   logic [DATA_WIDTH-1:0]   lane_shift;
   logic [DATA_WIDTH-1:0]   load_data;
   logic [DATA_WIDTH-1:0]   merged;

   // Illegal size or an address not aligned to the access size.
   assign req_bad = (req_size == 2'd3) ||
                    (req_size == 2'd1 && req_addr[0]) ||
                    (req_size == 2'd2 && req_addr[1:0] != 2'b00);

   // Bring the addressed lane down to bit 0, then extend. Halfwords are
   // guaranteed even-aligned here, so the shift only ever picks lane 0 or 2.
   assign lane_shift = mem_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_data = mem_rdata;
      unique case (size_q)
         2'd0:    load_data = {{(DATA_WIDTH-8){~uns_q & lane_shift[7]}}, lane_shift[7:0]};
         2'd1:    load_data = {{(DATA_WIDTH-16){~uns_q & lane_shift[15]}}, lane_shift[15:0]};
         default: load_data = mem_rdata;
      endcase
   end

   // Merge store data into the word captured during READ.
   always_comb begin
      merged = word_q;
      unique case (size_q)
         2'd0:    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'd1:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_bad)
                  state_nxt = ERR;
               else if (req_we && req_size == 2'd2)
                  state_nxt = WRITE;
               else
                  state_nxt = READ;
            end
         end
         READ:    state_nxt = we_q ? WRITE : RESP;
         WRITE:   state_nxt = RESP;
         ERR:     state_nxt = RESP;
         RESP:    state_nxt = resp_ready ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         size_q     <= 2'd0;
         uns_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  size_q     <= req_size;
                  uns_q      <= req_unsigned;
                  addr_q     <= req_addr;
                  wdata_q    <= req_wdata;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
               end
            end
            READ: begin
               word_q <= mem_rdata;
               if (!we_q)
                  resp_rdata <= load_data;
            end
            ERR: begin
               resp_err   <= 1'b1;
               resp_rdata <= '0;
            end
            RESP: begin
               if (resp_ready)
                  resp_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Decoded straight from the state register so reset kills a write at once.
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign mem_we     = (state == WRITE);
   assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_wdata  = (state == WRITE) ? merged : '0;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Data memory: async read, sync write, plus a preload port for the bench.
   logic [31:0] dmem [0:16383] = '{default: 32'h0};
   logic        pre_we = 1'b0;
   logic [13:0] pre_idx = '0;
   logic [31:0] pre_dat = '0;

   assign mem_rdata = dmem[mem_addr[15:2]];

   always @(posedge clk) begin
      if (mem_we)
         dmem[mem_addr[15:2]] <= mem_wdata;
      else if (pre_we)
         dmem[pre_idx] <= pre_dat;
   end

   // Reference model: flat byte-addressed memory.
   logic [7:0] rb [0:65535] = '{default: 8'h0};

   function automatic logic [31:0] ref_word(input int idx);
      return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
   endfunction

   function automatic logic ref_bad(input logic [1:0] size, input logic [15:0] a);
      return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                            input logic [15:0] a);
      logic [31:0] v;
      int          ai;
      ai = int'(a);
      if (size == 2'd0) begin
         v = {24'h0, rb[ai]};
         if (!uns && v[7]) v = v - 32'd256;
      end else if (size == 2'd1) begin
         v = {16'h0, rb[ai+1], rb[ai]};
         if (!uns && v[15]) v = v - 32'd65536;
      end else begin
         v = {rb[ai+3], rb[ai+2], rb[ai+1], rb[ai]};
      end
      return v;
   endfunction

   task automatic ref_store(input logic [1:0] size, input logic [15:0] a, input logic [31:0] wd);
      int nb;
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      for (int i = 0; i < nb; i++)
         rb[int'(a) + i] = wd[8*i +: 8];
   endtask

   function automatic int mem_diff();
      int d = 0;
      for (int i = 0; i < 16384; i++)
         if (dmem[i] !== ref_word(i)) d++;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_we  = 1'b1;
      pre_idx = a[15:2];
      pre_dat = d;
      @(posedge clk);
      #1 pre_we = 1'b0;
      for (int i = 0; i < 4; i++)
         rb[{a[15:2], 2'b00} + i] = d[8*i +: 8];
   endtask

   // One full transaction checked against the model. Latency is counted in
   // cycles after the accept edge, sampled on the falling edge.
   task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                       input logic [15:0] a, input logic [31:0] wd, input int stall,
                       output logic [31:0] rdata, output logic err);
      logic        bad;
      logic [31:0] exp_rd;
      int          exp_lat, exp_we, lat, nwe;
      bad     = ref_bad(size, a);
      exp_rd  = (bad || we) ? 32'h0 : ref_load(size, uns, a);
      exp_we  = (bad || !we) ? 0 : 1;
      exp_lat = (!bad && we && size != 2'd2) ? 3 : 2;

      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      resp_ready = (stall == 0);
      chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;

      lat = 0;
      nwe = 0;
      do begin
         @(negedge clk);
         lat++;
         if (mem_we) begin
            nwe++;
            chk("mem_addr", {16'h0, mem_addr}, {16'h0, a[15:2], 2'b00});
         end
      end while (!resp_valid && lat < 20);

      chk("latency", lat, exp_lat);
      chk("we_pulses", nwe, exp_we);
      chk("resp_err", {31'h0, resp_err}, {31'h0, bad});
      chk("resp_rdata", resp_rdata, exp_rd);
      rdata = resp_rdata;
      err   = resp_err;
      if (we && !bad) ref_store(size, a, wd);

      for (int s = 0; s < stall; s++) begin
         if (s == 1) begin
            // Request during the stall must be ignored.
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
            req_addr = 16'h003C; req_wdata = 32'h5555_5555;
         end
         if (s == 2) req_valid = 1'b0;
         @(negedge clk);
         chk("stall_valid", {31'h0, resp_valid}, 32'h1);
         chk("stall_rdata", resp_rdata, exp_rd);
         chk("stall_ready", {31'h0, req_ready}, 32'h0);
         chk("stall_we", {31'h0, mem_we}, 32'h0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_valid", {31'h0, resp_valid}, 32'h0);
      chk("post_err", {31'h0, resp_err}, 32'h0);
      chk("post_ready", {31'h0, req_ready}, 32'h1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [1:0]  sz;
      logic [15:0] ra;

      rst_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
      #1;
      chk("rst_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_err", {31'h0, resp_err}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_we", {31'h0, mem_we}, 32'h0);
      chk("rst_addr", {16'h0, mem_addr}, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Word store then load.
      xact(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 0, rd, er);
      xact(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 0, rd, er);
      chk("word_load", rd, 32'hDEADBEEF);

      // Byte read-modify-write.
      preload(16'h0020, 32'h11223344);
      xact(1'b1, 2'd0, 1'b0, 16'h0022, 32'h000000AA, 0, rd, er);
      chk("rmw_byte", dmem[8], 32'h11AA3344);
      xact(1'b0, 2'd0, 1'b0, 16'h0022, 32'h0, 0, rd, er);
      chk("lb_signed", rd, 32'hFFFFFFAA);
      xact(1'b0, 2'd0, 1'b1, 16'h0022, 32'h0, 0, rd, er);
      chk("lb_unsigned", rd, 32'h000000AA);

      // Halfword store and loads.
      xact(1'b1, 2'd1, 1'b0, 16'h0032, 32'h00008001, 0, rd, er);
      chk("rmw_half", dmem[12], 32'h80010000);
      xact(1'b0, 2'd1, 1'b0, 16'h0032, 32'h0, 0, rd, er);
      chk("lh_signed", rd, 32'hFFFF8001);
      xact(1'b0, 2'd1, 1'b1, 16'h0032, 32'h0, 0, rd, er);
      chk("lh_unsigned", rd, 32'h00008001);

      // Error cases leave memory untouched.
      xact(1'b1, 2'd2, 1'b0, 16'h0013, 32'hCAFEF00D, 0, rd, er);
      chk("err_sw_mis", {31'h0, er}, 32'h1);
      xact(1'b0, 2'd1, 1'b0, 16'h0001, 32'h0, 0, rd, er);
      chk("err_lh_mis", {31'h0, er}, 32'h1);
      xact(1'b1, 2'd3, 1'b0, 16'h0000, 32'h12345678, 0, rd, er);
      chk("err_size3", {31'h0, er}, 32'h1);
      chk("err_mem_image", mem_diff(), 0);

      // Backpressure on a load response.
      xact(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 5, rd, er);
      chk("bp_mem_image", mem_diff(), 0);

      // Randomized traffic over a small window so accesses overlap.
      for (int n = 0; n < 60; n++) begin
         sz = 2'($urandom_range(0, 3));
         ra = 16'($urandom_range(0, 127));
         xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ra, $urandom,
              ($urandom_range(0, 5) == 0) ? 2 : 0, rd, er);
      end
      chk("rand_mem_image", mem_diff(), 0);

      // Reset while a byte store is in its write cycle.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 16'h0101; req_wdata = 32'h00000077;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 chk("mid_we_high", {31'h0, mem_we}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_we_drop", {31'h0, mem_we}, 32'h0);
      chk("mid_ready", {31'h0, req_ready}, 32'h1);
      chk("mid_valid", {31'h0, resp_valid}, 32'h0);
      chk("mid_err", {31'h0, resp_err}, 32'h0);
      chk("mid_rdata", resp_rdata, 32'h0);
      chk("mid_addr", {16'h0, mem_addr}, 32'h0);
      chk("mid_wdata", mem_wdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("mid_word", dmem[64], ref_word(64));
      rst_n = 1'b1;

      xact(1'b0, 2'd0, 1'b1, 16'h0101, 32'h0, 0, rd, er);
      chk("final_mem_image", mem_diff(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
